// File: rtl/rbank_pkg.sv
// Shared definitions for the complex register-bank micro-sequencer:
// instruction layout, NOP opcode, FSM encoding and constant-table indices.
package rbank_pkg;

  localparam int INSTR_W  = 20;
  localparam int OP_LSB   = 16;
  localparam int OP_W     = 4;
  localparam int DST_LSB  = 12;
  localparam int SRCA_LSB = 8;
  localparam int SRCB_LSB = 4;
  localparam int REG_W    = 4;
  localparam int CA_BIT   = 3;
  localparam int CB_BIT   = 2;
  localparam int ENDW_LSB = 0;
  localparam int ENDW_W   = 2;

  localparam logic [OP_W-1:0] OP_NOP = 4'hF;

  // Constant-table indices as seen on seloutA/B when cnstA/B is set.
  localparam logic [REG_W-1:0] K_0     = 4'd0;  //  0 + j0
  localparam logic [REG_W-1:0] K_1     = 4'd1;  //  1 + j0
  localparam logic [REG_W-1:0] K_J     = 4'd2;  //  0 + j1
  localparam logic [REG_W-1:0] K_1J    = 4'd3;  //  1 + j1
  localparam logic [REG_W-1:0] K_N1    = 4'd4;  // -1 + j0
  localparam logic [REG_W-1:0] K_NJ    = 4'd5;  //  0 - j1
  localparam logic [REG_W-1:0] K_N1NJ  = 4'd6;  // -1 - j1
  localparam logic [REG_W-1:0] K_N1J   = 4'd7;  // -1 + j1
  localparam logic [REG_W-1:0] K_1NJ   = 4'd8;  //  1 - j1

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WAIT = 3'd3,
    ST_WB   = 3'd4
  } state_e;

  // Field order matches the 20-bit instruction word, MSB first.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  dst;
    logic [REG_W-1:0]  srca;
    logic [REG_W-1:0]  srcb;
    logic              ca;
    logic              cb;
    logic [ENDW_W-1:0] endw;
  } instr_t;

endpackage

// File: rtl/rbank_seq_if.sv
// Instruction handshake plus bank/ALU control bundle for rbank_seq.
// RBANK_SEQ_PERF_EN adds the perf_instr/perf_busy counters.
interface rbank_seq_if;
  import rbank_pkg::*;

  logic                instr_valid;
  logic                instr_ready;
  logic [INSTR_W-1:0]  instr;
  logic                enrregA;
  logic                enrregB;
  logic [REG_W-1:0]    seloutA;
  logic [REG_W-1:0]    seloutB;
  logic                cnstA;
  logic                cnstB;
  logic                regwen;
  logic [REG_W-1:0]    selwreg;
  logic [ENDW_W-1:0]   endwreg;
  logic                alu_start;
  logic [OP_W-1:0]     alu_op;
  logic                alu_done;
  logic                err_timeout;
  logic                busy;
`ifdef RBANK_SEQ_PERF_EN
  logic [15:0]         perf_instr;
  logic [15:0]         perf_busy;
`endif

  modport master (
    input  instr_valid, instr, alu_done,
    output instr_ready, enrregA, enrregB, seloutA, seloutB, cnstA, cnstB,
           regwen, selwreg, endwreg, alu_start, alu_op, err_timeout, busy
`ifdef RBANK_SEQ_PERF_EN
    , output perf_instr, perf_busy
`endif
  );

  modport slave (
    output instr_valid, instr, alu_done,
    input  instr_ready, enrregA, enrregB, seloutA, seloutB, cnstA, cnstB,
           regwen, selwreg, endwreg, alu_start, alu_op, err_timeout, busy
`ifdef RBANK_SEQ_PERF_EN
    , input perf_instr, perf_busy
`endif
  );

endinterface

// File: rtl/rbank_seq_timer.sv
// WAIT-state watchdog: cleared on WAIT entry, counts WAIT cycles,
// flags expiry once the count reaches TIMEOUT-1.
module rbank_seq_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q;

  assign expired = (cnt_q == 8'(TIMEOUT - 1));

  // Parks at the expiry value so a stuck enable cannot wrap it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                cnt_q <= '0;
    else if (clr)             cnt_q <= '0;
    else if (en && !expired)  cnt_q <= cnt_q + 8'd1;
  end

endmodule

// File: rtl/rbank_seq.sv
// Micro-sequencer driving bank reads, ALU start and write-back for one
// instruction at a time. RBANK_SEQ_PERF_EN enables perf counters.
module rbank_seq
  import rbank_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  rbank_seq_if.master bus
);

  state_e state_q, state_d;
  instr_t instr_q, cur;
  logic   accept, is_nop, expired, wait_clr, wait_en, act;

  logic              instr_ready_q, instr_ready_d, busy_q, busy_d;
  logic              enrreg_q, enrreg_d, alu_start_q, alu_start_d;
  logic              regwen_q, regwen_d, err_q, err_d;
  logic              cnstA_q, cnstA_d, cnstB_q, cnstB_d;
  logic [REG_W-1:0]  selA_q, selA_d, selB_q, selB_d, selw_q, selw_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ENDW_W-1:0] endw_q, endw_d;

  // In IDLE the live bus word is what gets latched, so outputs for READ
  // can be registered at the acceptance edge.
  assign cur      = (state_q == ST_IDLE) ? instr_t'(bus.instr) : instr_q;
  assign accept   = bus.instr_valid && (state_q == ST_IDLE);
  assign is_nop   = (cur.op == OP_NOP);
  assign wait_clr = (state_q == ST_EXEC);
  assign wait_en  = (state_q == ST_WAIT);

  rbank_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (wait_clr),
    .en      (wait_en),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (accept && !is_nop) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.alu_done) begin
          state_d = ST_WB;
        end else if (expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    act           = (state_d != ST_IDLE);
    instr_ready_d = !act;
    busy_d        = act;
    enrreg_d      = (state_d == ST_READ);
    alu_start_d   = (state_d == ST_EXEC);
    regwen_d      = (state_d == ST_WB);
    selA_d        = act ? cur.srca : '0;
    selB_d        = act ? cur.srcb : '0;
    cnstA_d       = act & cur.ca;
    cnstB_d       = act & cur.cb;
    op_d          = act ? cur.op   : '0;
    selw_d        = act ? cur.dst  : '0;
    endw_d        = act ? cur.endw : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      instr_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      enrreg_q      <= 1'b0;
      alu_start_q   <= 1'b0;
      regwen_q      <= 1'b0;
      err_q         <= 1'b0;
      selA_q        <= '0;
      selB_q        <= '0;
      cnstA_q       <= 1'b0;
      cnstB_q       <= 1'b0;
      op_q          <= '0;
      selw_q        <= '0;
      endw_q        <= '0;
    end else begin
      state_q       <= state_d;
      if (accept && !is_nop) instr_q <= cur;
      instr_ready_q <= instr_ready_d;
      busy_q        <= busy_d;
      enrreg_q      <= enrreg_d;
      alu_start_q   <= alu_start_d;
      regwen_q      <= regwen_d;
      err_q         <= err_d;
      selA_q        <= selA_d;
      selB_q        <= selB_d;
      cnstA_q       <= cnstA_d;
      cnstB_q       <= cnstB_d;
      op_q          <= op_d;
      selw_q        <= selw_d;
      endw_q        <= endw_d;
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.busy        = busy_q;
  assign bus.enrregA     = enrreg_q;
  assign bus.enrregB     = enrreg_q;
  assign bus.seloutA     = selA_q;
  assign bus.seloutB     = selB_q;
  assign bus.cnstA       = cnstA_q;
  assign bus.cnstB       = cnstB_q;
  assign bus.alu_start   = alu_start_q;
  assign bus.alu_op      = op_q;
  assign bus.regwen      = regwen_q;
  assign bus.selwreg     = selw_q;
  assign bus.endwreg     = endw_q;
  assign bus.err_timeout = err_q;

`ifdef RBANK_SEQ_PERF_EN
  logic [15:0] perf_instr_q, perf_busy_q;
  logic        done_evt;

  // Completed work only: write-backs and accepted NOPs, never aborts.
  assign done_evt = (state_q == ST_WB) || (accept && is_nop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_instr_q <= '0;
      perf_busy_q  <= '0;
    end else begin
      if (done_evt && perf_instr_q != 16'hFFFF) perf_instr_q <= perf_instr_q + 16'd1;
      if (busy_q && perf_busy_q != 16'hFFFF)    perf_busy_q  <= perf_busy_q + 16'd1;
    end
  end

  assign bus.perf_instr = perf_instr_q;
  assign bus.perf_busy  = perf_busy_q;
`endif

endmodule

// File: tb/tb_rbank_seq.sv
// Scoreboard bench for rbank_seq: issue() pushes expected READ/EXEC/WB/ERR
// events with their cycle stamps; a negedge monitor pops and compares.
module tb_rbank_seq;
  import rbank_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rbank_seq_if bus();

  rbank_seq #(.TIMEOUT(TO)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef enum int {EV_RD = 0, EV_EX = 1, EV_WB = 2, EV_ERR = 3} ev_e;
  typedef struct {
    ev_e         kind;
    int          cyc;
    logic [31:0] f;
  } exp_t;

  exp_t sb[$];
  int   dq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ALU model: pulses alu_done dly cycles after alu_start (0 = never).
  initial begin
    int d;
    bus.alu_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.alu_start && dq.size() > 0) begin
        d = dq.pop_front();
        if (d > 0) begin
          repeat (d) @(negedge clk);
          if (!rst) bus.alu_done = 1'b1;
          @(negedge clk);
          bus.alu_done = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    ev_e         k;
    logic [31:0] f;
    exp_t        e;
    bit          hit;
    hit = 1'b1;
    k   = EV_RD;
    f   = '0;
    if (!rst) begin
      if (bus.err_timeout)     begin k = EV_ERR; f = '0; end
      else if (bus.regwen)     begin k = EV_WB;  f = {26'd0, bus.selwreg, bus.endwreg}; end
      else if (bus.alu_start)  begin k = EV_EX;  f = {20'd0, bus.alu_op, bus.seloutA, bus.seloutB}; end
      else if (bus.enrregA)    begin k = EV_RD;
        f = {21'd0, bus.enrregB, bus.cnstA, bus.cnstB, bus.seloutA, bus.seloutB}; end
      else hit = 1'b0;
      if (hit) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", k, cyc);
        end else begin
          e = sb.pop_front();
          chk("event_kind",   32'(k), 32'(e.kind));
          chk("event_cycle",  32'(cyc), 32'(e.cyc));
          chk("event_fields", f, e.f);
        end
      end
    end
  end

  // Called and returns just after a negedge; acc = acceptance edge index.
  task automatic issue(input logic [3:0] op, input logic [3:0] dst, input logic [3:0] sa,
                       input logic [3:0] sbs, input logic ca, input logic cb,
                       input logic [1:0] ew, input int dly, output int acc);
    int   guard;
    exp_t e;
    guard = 0;
    bus.instr       = {op, dst, sa, sbs, ca, cb, ew};
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.instr_ready) begin
      chk("accept_timeout", 32'(bus.instr_ready), 32'd1);
      bus.instr_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (op != OP_NOP) begin
      dq.push_back(dly);
      e.kind = EV_RD; e.cyc = acc;     e.f = {21'd0, 1'b1, ca, cb, sa, sbs}; sb.push_back(e);
      e.kind = EV_EX; e.cyc = acc + 1; e.f = {20'd0, op, sa, sbs};           sb.push_back(e);
      if (dly > 0 && dly <= TO) begin
        e.kind = EV_WB; e.cyc = acc + dly + 2; e.f = {26'd0, dst, ew};
      end else begin
        e.kind = EV_ERR; e.cyc = acc + TO + 2; e.f = '0;
      end
      sb.push_back(e);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || !bus.instr_ready) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 200) begin
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int a, a2;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("in_reset_strobes", {bus.regwen, bus.alu_start, bus.enrregA, bus.busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(bus.instr_ready), 32'd1);
    chk("reset_idle", {bus.busy, bus.err_timeout, bus.seloutA, bus.seloutB, bus.selwreg}, 32'd0);

    // Basic op, ALU latency 3; ready must return the cycle after WB.
    issue(4'd2, 4'd5, 4'd1, 4'd2, 1'b0, 1'b0, 2'b00, 3, a);
    wait_cyc(a + 6);
    chk("ready_after_wb", {bus.instr_ready, bus.busy}, 32'b10);
    drain();

    // Constant read on port A, swapped write-back code.
    issue(4'd1, 4'hA, 4'd3, 4'd7, 1'b1, 1'b0, 2'b11, 2, a);
    drain();

    // Four NOPs with valid held: one per cycle, never leaving IDLE.
    bus.instr       = {OP_NOP, 16'h1234};
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("nop_ready", {bus.instr_ready, bus.busy}, 32'b10);
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("nop_idle", 32'(bus.busy), 32'd0);

    // Back-to-back at ALU latency 1: accepts 5 cycles apart.
    issue(4'd3, 4'd1, 4'd4, 4'd5, 1'b0, 1'b1, 2'b01, 1, a);
    issue(4'd4, 4'd2, 4'd6, 4'd8, 1'b1, 1'b1, 2'b10, 1, a2);
    chk("throughput", 32'(a2 - a), 32'd5);
    drain();

    // Stray alu_done in IDLE must not trigger anything.
    bus.alu_done = 1'b1;
    @(negedge clk);
    bus.alu_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_done_idle", {bus.busy, bus.instr_ready}, 32'b01);

    // Timeout: no alu_done at all.
    issue(4'd5, 4'd3, 4'd2, 4'd1, 1'b0, 1'b0, 2'b00, 0, a);
    wait_cyc(a + TO + 3);
    chk("ready_after_timeout", {bus.instr_ready, bus.busy, bus.err_timeout}, 32'b100);
    drain();

    // alu_done on the expiry cycle: write-back wins, no error.
    issue(4'd6, 4'd9, 4'd1, 4'd1, 1'b0, 1'b0, 2'b10, TO, a);
    drain();

    // Async reset while in WAIT.
    issue(4'd7, 4'd4, 4'd2, 4'd3, 1'b0, 1'b0, 2'b00, 0, a);
    wait_cyc(a + 4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_zero", {bus.enrregA, bus.enrregB, bus.seloutA, bus.seloutB, bus.cnstA,
        bus.cnstB, bus.regwen, bus.selwreg, bus.endwreg, bus.alu_start, bus.alu_op,
        bus.err_timeout, bus.busy}, 32'd0);
    sb.delete();
    dq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("ready_after_reset", {bus.instr_ready, bus.busy}, 32'b10);

    issue(4'd2, 4'd6, 4'd1, 4'd2, 1'b0, 1'b0, 2'b01, 1, a);
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
